// File: rtl/register_file_param.sv
// Parametrised register file: DWIDTH x 2**AWIDTH, NREAD combinational read ports, reg 0 hardwired to zero,
// plus a one-register-per-cycle clear sequencer. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module register_file_param #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int NREAD  = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      WEN,
    input  logic [AWIDTH-1:0]         wsel,
    input  logic [DWIDTH-1:0]         wdat,
    input  logic [NREAD*AWIDTH-1:0]   rsel,
    output logic [NREAD*DWIDTH-1:0]   rdat,
    input  logic                      clr_req,
    output logic                      busy
);

    localparam int NREGS = 2 ** AWIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic [DWIDTH-1:0]   regs_q [NREGS];
    logic                wr_en_s;

    // A write only lands while idle and never on the hardwired zero register.
    assign wr_en_s = WEN && (state_q == IDLE) && (wsel != {AWIDTH{1'b0}});
    assign busy    = (state_q == CLEAR);

    // Clear sequencer next-state: walks cnt from 1 up to NREGS-1, then rewinds to 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = AWIDTH'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_q == AWIDTH'(NREGS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = AWIDTH'(1);
                end else begin
                    cnt_d = cnt_q + AWIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = AWIDTH'(1);
            end
        endcase
    end

    // Sequencer state and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= AWIDTH'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage: normal writes while idle, one register zeroed per cycle while clearing.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DWIDTH{1'b0}};
            end
        end else if (state_q == CLEAR) begin
            regs_q[cnt_q] <= {DWIDTH{1'b0}};
        end else if (wr_en_s) begin
            regs_q[wsel] <= wdat;
        end
    end

    // Combinational read ports; select 0 always yields zero.
    always_comb begin
        rdat = {(NREAD*DWIDTH){1'b0}};
        for (int p = 0; p < NREAD; p++) begin
            if (rsel[p*AWIDTH +: AWIDTH] == {AWIDTH{1'b0}}) begin
                rdat[p*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
            end else if (wr_en_s && (rsel[p*AWIDTH +: AWIDTH] == wsel)) begin
                rdat[p*DWIDTH +: DWIDTH] = wdat;
`endif
            end else begin
                rdat[p*DWIDTH +: DWIDTH] = regs_q[rsel[p*AWIDTH +: AWIDTH]];
            end
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed self-checking bench for register_file_param at default parameters (32 x 32, 2 read ports).
module tb_register_file_param;

    logic        CLK;
    logic        nRST;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [9:0]  rsel;
    logic [63:0] rdat;
    logic        clr_req;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int busy_cycles;
    int k;
    logic [31:0] exp_byp;

    register_file_param #(.DWIDTH(32), .AWIDTH(5), .NREAD(2)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .WEN     (WEN),
        .wsel    (wsel),
        .wdat    (wdat),
        .rsel    (rsel),
        .rdat    (rdat),
        .clr_req (clr_req),
        .busy    (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WEN  = 1'b1;
        wsel = a;
        wdat = d;
        @(posedge CLK);
        #1;
        WEN  = 1'b0;
    endtask

    task automatic rd0(input logic [4:0] a, output logic [31:0] d);
        rsel[4:0] = a;
        #1;
        d = rdat[31:0];
    endtask

    logic [31:0] v;

    initial begin
        nRST = 1'b0; WEN = 1'b0; wsel = 5'd0; wdat = 32'd0; rsel = 10'd0; clr_req = 1'b0;
        #2;
        rsel = {5'd9, 5'd4};
        #1;
        check_val("reset_rd0", rdat[31:0], 32'd0);
        check_val("reset_rd1", rdat[63:32], 32'd0);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        #9 nRST = 1'b1;
        @(posedge CLK); #1;

        // basic write and dual-port read of the same register
        wr(5'd5, 32'hDEADBEEF);
        rsel = {5'd5, 5'd5};
        #1;
        check_val("wr5_rd0", rdat[31:0], 32'hDEADBEEF);
        check_val("wr5_rd1", rdat[63:32], 32'hDEADBEEF);

        wr(5'd0, 32'hFFFFFFFF);
        rd0(5'd0, v);
        check_val("wr0_dropped", v, 32'd0);

        // same-cycle read of the register being written
        WEN = 1'b1; wsel = 5'd7; wdat = 32'h12345678; rsel = {5'd5, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h12345678;
`else
        exp_byp = 32'd0;
`endif
        check_val("bypass_pre_edge", rdat[31:0], exp_byp);
        check_val("bypass_other_port", rdat[63:32], 32'hDEADBEEF);
        @(posedge CLK); #1;
        WEN = 1'b0;
        #1;
        check_val("bypass_post_edge", rdat[31:0], 32'h12345678);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        rsel = {5'd11, 5'd31};
        #1;
        check_val("preload_r31", rdat[31:0], 32'd31);
        check_val("preload_r11", rdat[63:32], 32'd11);

        // clear pulse; a write in the request cycle still commits
        clr_req = 1'b1; WEN = 1'b1; wsel = 5'd3; wdat = 32'd33;
        @(posedge CLK); #1;
        clr_req = 1'b0;
        WEN = 1'b1; wsel = 5'd31; wdat = 32'hA5A5A5A5;
        busy_cycles = busy ? 1 : 0;
        rd0(5'd3, v);
        check_val("clr_req_cycle_write", v, 32'd33);
        k = 0;
        while (busy && k < 40) begin
            @(posedge CLK); #1;
            k++;
            if (busy) busy_cycles++;
            if (k == 10) begin
                rsel = {5'd11, 5'd10};
                #1;
                check_val("clr_mid_r10", rdat[31:0], 32'd0);
                check_val("clr_mid_r11", rdat[63:32], 32'd11);
            end
            if (k == 20) begin
                rd0(5'd31, v);
                check_val("clr_wr_ignored", v, 32'd31);
                WEN = 1'b0;
            end
        end
        WEN = 1'b0;
        check_val("clr_busy_cycles", 32'(busy_cycles), 32'd31);
        for (int i = 1; i < 32; i++) begin
            rd0(5'(i), v);
            check_val($sformatf("clr_done_r%0d", i), v, 32'd0);
        end

        // clr_req held high: one idle cycle between sequences
        clr_req = 1'b1;
        @(posedge CLK); #1;
        check_val("hold_busy_start", {31'd0, busy}, 32'd1);
        k = 0;
        while (busy && k < 40) begin
            @(posedge CLK); #1;
            k++;
        end
        check_val("hold_first_len", 32'(k), 32'd31);
        check_val("hold_gap_low", {31'd0, busy}, 32'd0);
        @(posedge CLK); #1;
        check_val("hold_restart", {31'd0, busy}, 32'd1);
        clr_req = 1'b0;
        k = 0;
        while (busy && k < 40) begin
            @(posedge CLK); #1;
            k++;
        end
        check_val("hold_second_done", {31'd0, busy}, 32'd0);

        // reset in the middle of a clear
        wr(5'd20, 32'd20);
        clr_req = 1'b1;
        @(posedge CLK); #1;
        clr_req = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        rd0(5'd20, v);
        check_val("midclr_r20_before", v, 32'd20);
        #1 nRST = 1'b0;
        #1;
        rd0(5'd20, v);
        check_val("midclr_r20_zero", v, 32'd0);
        check_val("midclr_busy", {31'd0, busy}, 32'd0);
        #1 nRST = 1'b1;
        @(posedge CLK); #1;
        wr(5'd9, 32'h0000_0099);
        rd0(5'd9, v);
        check_val("post_reset_write", v, 32'h0000_0099);
        check_val("post_reset_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
